// File: rtl/ram_256x64_arb_if.sv
// ram_256x64_arb_if: one requester port of the RAM arbiter.
//   REQ    requester -> arbiter  access request, held stable until GNT
//   WE     requester -> arbiter  byte write enables (0 = read)
//   A      requester -> arbiter  word address
//   Di     requester -> arbiter  write data
//   GNT    arbiter -> requester  request accepted this cycle
//   RVALID arbiter -> requester  one-cycle pulse, Do holds read data
//   Do     arbiter -> requester  read data (held until next RVALID)
interface ram_256x64_arb_if;
  logic        REQ;
  logic [7:0]  WE;
  logic [7:0]  A;
  logic [63:0] Di;
  logic        GNT;
  logic        RVALID;
  logic [63:0] Do;

  modport master (output REQ, WE, A, Di, input GNT, RVALID, Do);
  modport slave  (input REQ, WE, A, Di, output GNT, RVALID, Do);
endinterface

// File: rtl/ram_256x64_arb.sv
// ram_256x64_arb: round-robin arbiter/sequencer for two requesters sharing one
// 256x64 single-port RAM with byte write enables.
//   CLK, RST_N   clock and asynchronous active-low reset
//   m0, m1       requester ports (ram_256x64_arb_if.slave)
//   RAM_EN/WE/A/Di  RAM control, combinational from the granted request
//   RAM_Do       RAM read data, valid the cycle after a read access
// Parameter INIT_PRIO selects the requester winning the first contested cycle.
// Optional macro ARB_RDATA_REG_EN adds a read-data register stage (latency 2).
module ram_256x64_arb #(
  parameter int unsigned INIT_PRIO = 0
) (
  input  logic                  CLK,
  input  logic                  RST_N,
  ram_256x64_arb_if.slave       m0,
  ram_256x64_arb_if.slave       m1,
  output logic                  RAM_EN,
  output logic [7:0]            RAM_WE,
  output logic [7:0]            RAM_A,
  output logic [63:0]           RAM_Di,
  input  logic [63:0]           RAM_Do
);

  localparam int unsigned DW = 64;
  localparam int unsigned AW = 8;
  localparam int unsigned BW = DW / 8;
  // LAST starts at the other requester so INIT_PRIO wins first.
  localparam logic LAST_RST = (INIT_PRIO == 0) ? 1'b1 : 1'b0;

  logic          last_q, last_d;
  logic          pend_valid_q, pend_valid_d;
  logic          pend_id_q, pend_id_d;
  logic [DW-1:0] do0_q, do0_d;
  logic [DW-1:0] do1_q, do1_d;

  logic          gnt0, gnt1, any_gnt;
  logic          src_valid, src_id;
  logic [DW-1:0] src_data;
  logic          rvalid0, rvalid1;

`ifdef ARB_RDATA_REG_EN
  logic          rd_valid_q, rd_valid_d;
  logic          rd_id_q, rd_id_d;
  logic [DW-1:0] rd_data_q, rd_data_d;
`endif

  // Grant, RAM port mux, pending-read tracking and read-data return.
  always_comb begin
    // Grants are gated by reset so the RAM port is quiet while RST_N is low.
    gnt0    = RST_N & m0.REQ & (~m1.REQ | last_q);
    gnt1    = RST_N & m1.REQ & (~m0.REQ | ~last_q);
    any_gnt = gnt0 | gnt1;

    RAM_EN = any_gnt;
    RAM_WE = BW'(0);
    RAM_A  = AW'(0);
    RAM_Di = DW'(0);
    if (gnt0) begin
      RAM_WE = m0.WE;
      RAM_A  = m0.A;
      RAM_Di = m0.Di;
    end else if (gnt1) begin
      RAM_WE = m1.WE;
      RAM_A  = m1.A;
      RAM_Di = m1.Di;
    end

    last_d       = any_gnt ? gnt1 : last_q;
    pend_valid_d = any_gnt && (RAM_WE == BW'(0));
    pend_id_d    = gnt1;

`ifdef ARB_RDATA_REG_EN
    rd_valid_d = pend_valid_q;
    rd_id_d    = pend_id_q;
    rd_data_d  = RAM_Do;
    src_valid  = rd_valid_q;
    src_id     = rd_id_q;
    src_data   = rd_data_q;
`else
    src_valid  = pend_valid_q;
    src_id     = pend_id_q;
    src_data   = RAM_Do;
`endif

    rvalid0 = src_valid & ~src_id;
    rvalid1 = src_valid & src_id;

    m0.GNT    = gnt0;
    m1.GNT    = gnt1;
    m0.RVALID = rvalid0;
    m1.RVALID = rvalid1;
    // Returned data is visible in the RVALID cycle and held afterwards.
    m0.Do     = rvalid0 ? src_data : do0_q;
    m1.Do     = rvalid1 ? src_data : do1_q;
    do0_d     = m0.Do;
    do1_d     = m1.Do;
  end

  // State registers.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      last_q       <= LAST_RST;
      pend_valid_q <= 1'b0;
      pend_id_q    <= 1'b0;
      do0_q        <= DW'(0);
      do1_q        <= DW'(0);
`ifdef ARB_RDATA_REG_EN
      rd_valid_q   <= 1'b0;
      rd_id_q      <= 1'b0;
      rd_data_q    <= DW'(0);
`endif
    end else begin
      last_q       <= last_d;
      pend_valid_q <= pend_valid_d;
      pend_id_q    <= pend_id_d;
      do0_q        <= do0_d;
      do1_q        <= do1_d;
`ifdef ARB_RDATA_REG_EN
      rd_valid_q   <= rd_valid_d;
      rd_id_q      <= rd_id_d;
      rd_data_q    <= rd_data_d;
`endif
    end
  end

endmodule

// File: tb/tb_ram_256x64_arb.sv
// tb_ram_256x64_arb: directed self-checking bench for ram_256x64_arb with a
// behavioural 256x64 byte-enable RAM behind it.
module tb_ram_256x64_arb;

`ifdef ARB_RDATA_REG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic        CLK = 1'b0;
  logic        RST_N;
  logic        RAM_EN;
  logic [7:0]  RAM_WE;
  logic [7:0]  RAM_A;
  logic [63:0] RAM_Di;
  logic [63:0] RAM_Do;

  int checks = 0;
  int failures = 0;

  logic [63:0] mem [256];
  logic [63:0] exp_mem [256];
  bit          mem_init = 1'b0;

  ram_256x64_arb_if m0_if ();
  ram_256x64_arb_if m1_if ();

  ram_256x64_arb #(.INIT_PRIO(0)) dut (
    .CLK    (CLK),
    .RST_N  (RST_N),
    .m0     (m0_if),
    .m1     (m1_if),
    .RAM_EN (RAM_EN),
    .RAM_WE (RAM_WE),
    .RAM_A  (RAM_A),
    .RAM_Di (RAM_Di),
    .RAM_Do (RAM_Do)
  );

  always #5 CLK = ~CLK;

  function automatic logic [63:0] pat(input int unsigned i);
    return {8'(i), 8'(255 - i), 16'h5AC3, 32'(i * 32'h0101_0101)};
  endfunction

  // Synchronous RAM: read data appears after the edge that samples the read.
  always @(posedge CLK) begin
    if (!mem_init) begin
      for (int i = 0; i < 256; i++) mem[i] <= pat(i);
      mem_init <= 1'b1;
    end else if (RAM_EN) begin
      if (RAM_WE != 8'h00) begin
        for (int b = 0; b < 8; b++)
          if (RAM_WE[b]) mem[RAM_A][b*8 +: 8] <= RAM_Di[b*8 +: 8];
      end else begin
        RAM_Do <= mem[RAM_A];
      end
    end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Apply one cycle of requests at the falling edge, then settle before checks.
  task automatic drive(input logic r0, input logic [7:0] w0, input logic [7:0] a0,
                       input logic [63:0] d0, input logic r1, input logic [7:0] w1,
                       input logic [7:0] a1, input logic [63:0] d1);
    @(negedge CLK);
    m0_if.REQ = r0; m0_if.WE = w0; m0_if.A = a0; m0_if.Di = d0;
    m1_if.REQ = r1; m1_if.WE = w1; m1_if.A = a1; m1_if.Di = d1;
    #1;
  endtask

  task automatic idle();
    drive(1'b0, 8'h00, 8'h00, 64'h0, 1'b0, 8'h00, 8'h00, 64'h0);
  endtask

  localparam logic [63:0] D1  = 64'h0123_4567_89AB_CDEF;
  localparam logic [63:0] BEX = 64'hFFFF_FFFF_0000_0000;

  initial begin
    for (int i = 0; i < 256; i++) exp_mem[i] = pat(i);
    RST_N = 1'b0;
    idle();
    idle();

    // Requests while in reset are ignored and all outputs stay zero.
    drive(1'b1, 8'h00, 8'h05, 64'h0, 1'b1, 8'h00, 8'h06, 64'h0);
    check("rst_gnt0", 64'(m0_if.GNT), 64'd0);
    check("rst_gnt1", 64'(m1_if.GNT), 64'd0);
    check("rst_ram_en", 64'(RAM_EN), 64'd0);
    check("rst_ram_a", 64'(RAM_A), 64'd0);
    check("rst_rvalid0", 64'(m0_if.RVALID), 64'd0);
    check("rst_do0", m0_if.Do, 64'd0);
    check("rst_do1", m1_if.Do, 64'd0);
    @(negedge CLK);
    RST_N = 1'b1;

    // Single master full write, then read back.
    drive(1'b1, 8'hFF, 8'h10, D1, 1'b0, 8'h00, 8'h00, 64'h0);
    check("wr_gnt0", 64'(m0_if.GNT), 64'd1);
    check("wr_gnt1", 64'(m1_if.GNT), 64'd0);
    check("wr_ram_en", 64'(RAM_EN), 64'd1);
    check("wr_ram_we", 64'(RAM_WE), 64'hFF);
    check("wr_ram_a", 64'(RAM_A), 64'h10);
    check("wr_ram_di", RAM_Di, D1);
    drive(1'b1, 8'h00, 8'h10, 64'h0, 1'b0, 8'h00, 8'h00, 64'h0);
    check("rd_gnt0", 64'(m0_if.GNT), 64'd1);
    check("rd_ram_we", 64'(RAM_WE), 64'h00);
    check("wr_no_rvalid", 64'(m0_if.RVALID), 64'd0);
    repeat (LAT - 1) begin
      idle();
      check("rd_early_rvalid", 64'(m0_if.RVALID), 64'd0);
    end
    idle();
    check("rd_rvalid0", 64'(m0_if.RVALID), 64'd1);
    check("rd_rvalid1", 64'(m1_if.RVALID), 64'd0);
    check("rd_do0", m0_if.Do, D1);
    check("idle_ram_en", 64'(RAM_EN), 64'd0);
    check("idle_ram_a", 64'(RAM_A), 64'd0);
    check("idle_ram_di", RAM_Di, 64'd0);
    idle();
    check("rd_rvalid_pulse", 64'(m0_if.RVALID), 64'd0);
    check("rd_do0_hold", m0_if.Do, D1);
    exp_mem[8'h10] = D1;

    // Partial byte enables: low four bytes cleared, high four kept.
    drive(1'b1, 8'hFF, 8'hFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 8'h00, 8'h00, 64'h0);
    drive(1'b1, 8'h0F, 8'hFF, 64'h0, 1'b0, 8'h00, 8'h00, 64'h0);
    check("be_ram_we", 64'(RAM_WE), 64'h0F);
    drive(1'b1, 8'h00, 8'hFF, 64'h0, 1'b0, 8'h00, 8'h00, 64'h0);
    repeat (LAT - 1) idle();
    idle();
    check("be_rvalid0", 64'(m0_if.RVALID), 64'd1);
    check("be_do0", m0_if.Do, BEX);
    exp_mem[8'hFF] = BEX;

    // Reset during a read's grant cycle discards it.
    drive(1'b1, 8'h00, 8'h10, 64'h0, 1'b0, 8'h00, 8'h00, 64'h0);
    check("mid_gnt0", 64'(m0_if.GNT), 64'd1);
    RST_N = 1'b0;
    #1;
    check("mid_rst_gnt0", 64'(m0_if.GNT), 64'd0);
    check("mid_rst_do0", m0_if.Do, 64'd0);
    idle();
    idle();
    @(negedge CLK);
    RST_N = 1'b1;
    for (int i = 0; i < 3; i++) begin
      idle();
      check("post_rst_rvalid0", 64'(m0_if.RVALID), 64'd0);
      check("post_rst_rvalid1", 64'(m1_if.RVALID), 64'd0);
      check("post_rst_do0", m0_if.Do, 64'd0);
      check("post_rst_ram_en", 64'(RAM_EN), 64'd0);
    end

    // Contention: both read for 6 cycles, grants alternate starting at M0.
    for (int i = 0; i < 6 + LAT; i++) begin
      if (i < 6) drive(1'b1, 8'h00, 8'h10, 64'h0, 1'b1, 8'h00, 8'hFF, 64'h0);
      else idle();
      if (i < 6) begin
        check("ct_gnt0", 64'(m0_if.GNT), 64'((i % 2) == 0));
        check("ct_gnt1", 64'(m1_if.GNT), 64'((i % 2) == 1));
      end
      if (i >= LAT) begin
        check("ct_rvalid0", 64'(m0_if.RVALID), 64'(((i - LAT) % 2) == 0));
        check("ct_rvalid1", 64'(m1_if.RVALID), 64'(((i - LAT) % 2) == 1));
        if (((i - LAT) % 2) == 0) check("ct_do0", m0_if.Do, exp_mem[8'h10]);
        else                      check("ct_do1", m1_if.Do, exp_mem[8'hFF]);
      end else begin
        check("ct_rvalid_early", 64'(m0_if.RVALID | m1_if.RVALID), 64'd0);
      end
    end

    // Streaming reads from M1, one per cycle.
    for (int i = 0; i < 256 + LAT; i++) begin
      if (i < 256) drive(1'b0, 8'h00, 8'h00, 64'h0, 1'b1, 8'h00, 8'(i), 64'h0);
      else idle();
      if (i < 256) check("st_gnt1", 64'(m1_if.GNT), 64'd1);
      check("st_gnt0", 64'(m0_if.GNT), 64'd0);
      check("st_rvalid0", 64'(m0_if.RVALID), 64'd0);
      if (i >= LAT) begin
        check("st_rvalid1", 64'(m1_if.RVALID), 64'd1);
        check("st_do1", m1_if.Do, exp_mem[i - LAT]);
      end else begin
        check("st_rvalid1_early", 64'(m1_if.RVALID), 64'd0);
      end
    end
    idle();
    check("st_rvalid1_end", 64'(m1_if.RVALID), 64'd0);
    check("st_do1_hold", m1_if.Do, exp_mem[255]);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
